// File: rtl/cluster_periph_initiator_if.sv
// Bundle of the command, peripheral-bus and response signals of cluster_periph_initiator.
// The master view belongs to the initiator, which masters the bus. The slave view is the environment: the command source plus the peripheral.
interface cluster_periph_initiator_if #(
  parameter int ID_WIDTH = 5
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [31:0]         cmd_addr;
  logic                cmd_wen;
  logic [31:0]         cmd_wdata;
  logic [3:0]          cmd_be;

  logic                bus_req;
  logic [31:0]         bus_add;
  logic                bus_wen;
  logic [31:0]         bus_wdata;
  logic [3:0]          bus_be;
  logic [ID_WIDTH-1:0] bus_id;
  logic                bus_gnt;
  logic                bus_r_valid;
  logic                bus_r_opc;
  logic [ID_WIDTH-1:0] bus_r_id;
  logic [31:0]         bus_r_rdata;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic                busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_wen, cmd_wdata, cmd_be,
    input  bus_gnt, bus_r_valid, bus_r_opc, bus_r_id, bus_r_rdata,
    input  rsp_ready,
    output cmd_ready,
    output bus_req, bus_add, bus_wen, bus_wdata, bus_be, bus_id,
    output rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_wen, cmd_wdata, cmd_be,
    output bus_gnt, bus_r_valid, bus_r_opc, bus_r_id, bus_r_rdata,
    output rsp_ready,
    input  cmd_ready,
    input  bus_req, bus_add, bus_wen, bus_wdata, bus_be, bus_id,
    input  rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/cluster_periph_initiator.sv
// Single-outstanding XBAR_PERIPH_BUS initiator: it takes one command, requests the bus until granted, and returns the tagged response.
// Defining PERIPH_INIT_TIMEOUT_EN adds a response timeout of TIMEOUT_CYCLES cycles in WAIT_RSP.
module cluster_periph_initiator #(
  parameter int ID_WIDTH       = 5,
  parameter int MY_ID          = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  cluster_periph_initiator_if.master    pif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, RSP} state_t;

  localparam logic [ID_WIDTH-1:0] MY_ID_W = ID_WIDTH'(MY_ID);

  state_t      state_q, state_d;
  logic [31:0] add_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        wen_q, err_q;
  logic        rsp_match;
  logic        timeout_hit;

  // Only a tagged response seen while waiting counts. The qualification by state happens where the match is used.
  assign rsp_match = pif.bus_r_valid && (pif.bus_r_id == MY_ID_W);

`ifdef PERIPH_INIT_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;

  // The counter holds zero outside WAIT_RSP, so it starts cleared on every entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q != WAIT_RSP) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign timeout_hit = (state_q == WAIT_RSP) && (cnt_q == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (pif.cmd_valid)              state_d = REQ;
      REQ:      if (pif.bus_gnt)                state_d = WAIT_RSP;
      WAIT_RSP: if (rsp_match || timeout_hit)   state_d = RSP;
      RSP:      if (pif.rsp_ready)              state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples values from before the edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      add_q   <= '0;
      wen_q   <= 1'b1;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pif.cmd_valid) begin
        add_q   <= pif.cmd_addr;
        wen_q   <= pif.cmd_wen;
        wdata_q <= pif.cmd_wdata;
        be_q    <= pif.cmd_be;
      end
      // A matching response in the expiry cycle takes priority over the timeout.
      if (state_q == WAIT_RSP) begin
        if (rsp_match) begin
          rdata_q <= pif.bus_r_rdata;
          err_q   <= pif.bus_r_opc;
        end else if (timeout_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign pif.cmd_ready = (state_q == IDLE);
  assign pif.bus_req   = (state_q == REQ);
  assign pif.bus_add   = add_q;
  assign pif.bus_wen   = wen_q;
  assign pif.bus_wdata = wdata_q;
  assign pif.bus_be    = be_q;
  assign pif.bus_id    = MY_ID_W;
  assign pif.rsp_valid = (state_q == RSP);
  assign pif.rsp_rdata = rdata_q;
  assign pif.rsp_err   = err_q;
  assign pif.busy      = (state_q != IDLE);

endmodule
